// File: rtl/pwm_ramp_pkg.sv
// Shared types and defaults for the PWM duty-cycle ramp controller.
// Holds the FSM state encoding and the saturating step arithmetic.
package pwm_ramp_pkg;

    localparam int         PERIOD_W_DEFAULT  = 16;
    localparam logic [6:0] DUTY_ADDR_DEFAULT = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP,
        ST_DONE
    } state_t;

    // One ramp step toward target that never overshoots, wraps or underflows.
    function automatic logic [7:0] ramp_next(input logic [7:0] duty,
                                             input logic [7:0] step,
                                             input logic [7:0] target);
        logic [8:0]        sum;
        logic signed [8:0] diff;
        sum  = {1'b0, duty} + {1'b0, step};
        diff = $signed({1'b0, duty}) - $signed({1'b0, step});
        if (duty < target) begin
            ramp_next = (sum > {1'b0, target}) ? target : sum[7:0];
        end else if (duty > target) begin
            ramp_next = (diff < $signed({1'b0, target})) ? target : diff[7:0];
        end else begin
            ramp_next = duty;
        end
    endfunction

    // A zero step size would stall the ramp forever, so it is promoted to 1.
    function automatic logic [7:0] nonzero_step(input logic [7:0] step);
        nonzero_step = (step == 8'd0) ? 8'd1 : step;
    endfunction

endpackage

// File: rtl/pwm_ramp_controller_ramp_timer.sv
// Loadable down-counter that paces the ramp; zero marks the end of a wait interval.
module ramp_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramps the PWM duty cycle toward a target in fixed steps at a fixed pace;
// a direct SPI write to the duty register overrides and cancels any ramp.
module pwm_ramp_controller
    import pwm_ramp_pkg::*;
#(
    parameter int         PERIOD_W  = PERIOD_W_DEFAULT,
    parameter logic [6:0] DUTY_ADDR = DUTY_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          cfg_target,
    input  logic [7:0]          cfg_step,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                spi_wr_valid,
    input  logic [6:0]          spi_wr_addr,
    input  logic [7:0]          spi_wr_data,
    output logic [7:0]          duty_cycle,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    state_t              state, state_nxt;
    logic [7:0]          target_q, step_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cfg_period_eff;
    logic [PERIOD_W-1:0] tmr_load_val;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic                latch_cfg;
    logic                spi_hit;
    logic                ramp_active;
    logic [7:0]          stepped;
    logic [7:0]          duty_nxt;
    logic                done_nxt, aborted_nxt, busy_nxt;

    assign spi_hit        = spi_wr_valid && (spi_wr_addr == DUTY_ADDR);
    assign ramp_active    = (state == ST_WAIT) || (state == ST_STEP);
    assign cfg_period_eff = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
    assign stepped        = ramp_next(duty_cycle, step_q, target_q);

    ramp_timer #(.W(PERIOD_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        latch_cfg    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = period_q - PERIOD_W'(1);
        tmr_dec      = 1'b0;
        duty_nxt     = duty_cycle;
        aborted_nxt  = 1'b0;

        if (spi_hit) begin
            // Host write has priority over a same-cycle start or step.
            state_nxt   = ST_IDLE;
            duty_nxt    = spi_wr_data;
            aborted_nxt = ramp_active;
        end else if (start) begin
            latch_cfg    = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = cfg_period_eff - PERIOD_W'(1);
            state_nxt    = ST_WAIT;
        end else begin
            unique case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_WAIT: begin
                    if (tmr_zero) begin
                        state_nxt = ST_STEP;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_STEP: begin
                    duty_nxt = stepped;
                    if (stepped == target_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        tmr_load  = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end

        done_nxt = (state_nxt == ST_DONE);
        busy_nxt = (state_nxt == ST_WAIT) || (state_nxt == ST_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= 8'd0;
            step_q   <= 8'd0;
            period_q <= '0;
        end else if (latch_cfg) begin
            target_q <= cfg_target;
            step_q   <= nonzero_step(cfg_step);
            period_q <= cfg_period_eff;
        end
    end

    // Outputs are registered from next-state values, so they track the state
    // register exactly without any input-to-output combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cycle <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            duty_cycle <= duty_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed self-checking bench for pwm_ramp_controller with hand-computed expectations.
module tb_pwm_ramp_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_target;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_period;
    logic        spi_wr_valid;
    logic [6:0]  spi_wr_addr;
    logic [7:0]  spi_wr_data;
    logic [7:0]  duty_cycle;
    logic        busy;
    logic        done;
    logic        aborted;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    int abort_cnt  = 0;
    int both_cnt   = 0;

    pwm_ramp_controller #(.PERIOD_W(16), .DUTY_ADDR(7'h04)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_target   (cfg_target),
        .cfg_step     (cfg_step),
        .cfg_period   (cfg_period),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .duty_cycle   (duty_cycle),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later, tallying output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (done && aborted) both_cnt++;
    endtask

    task automatic do_start(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p);
        start = 1'b1; cfg_target = t; cfg_step = s; cfg_period = p;
        tick();
        start = 1'b0;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        spi_wr_valid = 1'b1; spi_wr_addr = a; spi_wr_data = d;
        tick();
        spi_wr_valid = 1'b0;
    endtask

    task automatic expect_duty(input string name, input logic [7:0] exp);
        vectors++;
        if (duty_cycle !== exp) begin
            miscompares++;
            $display("FAIL %s: duty_cycle=%0d expected %0d", name, duty_cycle, exp);
        end
    endtask

    task automatic expect_flags(input string name, input logic b, input logic d, input logic a);
        vectors++;
        if ({busy, done, aborted} !== {b, d, a}) begin
            miscompares++;
            $display("FAIL %s: busy/done/aborted=%b%b%b expected %b%b%b",
                     name, busy, done, aborted, b, d, a);
        end
    endtask

    task automatic expect_count(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: count=%0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cfg_target = '0; cfg_step = '0; cfg_period = '0;
        spi_wr_valid = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
        #3;
        expect_duty("reset_duty", 8'h00);
        expect_flags("reset_flags", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        expect_duty("post_reset_duty", 8'h00);
        expect_flags("post_reset_flags", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_up_ramp();
        logic [7:0] exp_seq [4];
        logic [7:0] prev;
        exp_seq = '{8'd3, 8'd6, 8'd9, 8'd10};
        prev = 8'd0;
        done_cnt = 0;
        do_start(8'd10, 8'd3, 16'd4);
        expect_flags("up_start_busy", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (4) tick();
            expect_duty($sformatf("up_hold%0d", k), prev);
            tick();
            expect_duty($sformatf("up_step%0d", k), exp_seq[k]);
            prev = exp_seq[k];
        end
        expect_flags("up_done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_flags("up_idle", 1'b0, 1'b0, 1'b0);
        expect_count("up_done_pulses", done_cnt, 1);
    endtask

    task automatic test_down_clamp();
        spi_write(7'h04, 8'd200);
        expect_duty("down_preload", 8'd200);
        expect_flags("down_preload_flags", 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        do_start(8'd5, 8'd100, 16'd1);
        tick(); expect_duty("down_n1", 8'd200);
        tick(); expect_duty("down_n2", 8'd100);
        tick(); expect_duty("down_n3", 8'd100);
        tick(); expect_duty("down_n4", 8'd5);
        expect_flags("down_done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_count("down_done_pulses", done_cnt, 1);
    endtask

    task automatic test_overflow_guard();
        spi_write(7'h04, 8'd250);
        do_start(8'd255, 8'd20, 16'd2);
        tick(); tick(); expect_duty("ovf_hold", 8'd250);
        tick(); expect_duty("ovf_step", 8'd255);
        expect_flags("ovf_done", 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_abort();
        done_cnt = 0; abort_cnt = 0;
        do_start(8'd0, 8'd10, 16'd3);
        repeat (4) tick();
        expect_duty("abort_first_step", 8'd245);
        tick();
        spi_write(7'h04, 8'h80);
        expect_duty("abort_duty", 8'h80);
        expect_flags("abort_flags", 1'b0, 1'b0, 1'b1);
        repeat (6) tick();
        expect_duty("abort_hold", 8'h80);
        expect_count("abort_pulses", abort_cnt, 1);
        expect_count("abort_no_done", done_cnt, 0);
    endtask

    task automatic test_collisions();
        done_cnt = 0; abort_cnt = 0;
        start = 1'b1; cfg_target = 8'hFF; cfg_step = 8'd1; cfg_period = 16'd1;
        spi_wr_valid = 1'b1; spi_wr_addr = 7'h04; spi_wr_data = 8'h33;
        tick();
        start = 1'b0; spi_wr_valid = 1'b0;
        expect_duty("coll_duty", 8'h33);
        expect_flags("coll_flags", 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        expect_duty("coll_hold", 8'h33);
        do_start(8'h60, 8'h10, 16'd2);
        spi_write(7'h02, 8'h00);
        tick(); tick(); expect_duty("other_addr_s1", 8'h43);
        repeat (3) tick(); expect_duty("other_addr_s2", 8'h53);
        repeat (3) tick(); expect_duty("other_addr_s3", 8'h60);
        expect_flags("other_addr_done", 1'b0, 1'b1, 1'b0);
        expect_count("coll_no_abort", abort_cnt, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        done_cnt = 0; abort_cnt = 0;
        do_start(8'h60, 8'd5, 16'd2);
        expect_flags("same_busy", 1'b1, 1'b0, 1'b0);
        tick(); tick(); expect_duty("same_step", 8'h60);
        tick();
        expect_flags("same_done", 1'b0, 1'b1, 1'b0);
        tick();
        done_cnt = 0;
        do_start(8'h70, 8'h10, 16'd3);
        tick(); tick();
        do_start(8'h50, 8'd8, 16'd1);
        expect_duty("restart_no_step", 8'h60);
        expect_flags("restart_busy", 1'b1, 1'b0, 1'b0);
        tick(); expect_duty("restart_m1", 8'h60);
        tick(); expect_duty("restart_m2", 8'h58);
        tick(); tick(); expect_duty("restart_m4", 8'h50);
        expect_count("restart_done_pulses", done_cnt, 1);
        expect_count("restart_no_abort", abort_cnt, 0);
        tick();
    endtask

    task automatic test_reset_mid_ramp();
        do_start(8'h10, 8'd0, 16'd0);
        tick(); tick(); expect_duty("zero_cfg_s1", 8'h4F);
        tick(); tick(); expect_duty("zero_cfg_s2", 8'h4E);
        #2 rst_n = 1'b0;
        #1;
        expect_duty("async_rst_duty", 8'h00);
        expect_flags("async_rst_flags", 1'b0, 1'b0, 1'b0);
        done_cnt = 0; abort_cnt = 0;
        tick(); tick();
        rst_n = 1'b1;
        do_start(8'd2, 8'd0, 16'd0);
        expect_flags("first_start_busy", 1'b1, 1'b0, 1'b0);
        tick(); tick(); expect_duty("rel_s1", 8'd1);
        tick();
        expect_count("rel_no_pulses", done_cnt + abort_cnt, 0);
        tick(); expect_duty("rel_s2", 8'd2);
        expect_flags("rel_done", 1'b0, 1'b1, 1'b0);
        tick();
        expect_count("done_aborted_overlap", both_cnt, 0);
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_clamp();
        test_overflow_guard();
        test_abort();
        test_collisions();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 Parameter: PERIOD_W, 16, width of step-period counter and cfg_period.
REQ-002 Parameter: DUTY_ADDR, 7'h04, SPI register address that owns the duty-cycle value.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; begin a ramp with the cfg_* values sampled on the same edge.
REQ-006 cfg_target  input  8  final duty-cycle value of the ramp.
REQ-007 cfg_step  input  8  duty increment/decrement per step; 0 is treated as 1.
REQ-008 cfg_period  input  PERIOD_W  clk cycles between steps; 0 is treated as 1.
REQ-009 spi_wr_valid  input  1  one-cycle strobe from the SPI peripheral's register-write path.
REQ-010 spi_wr_addr  input  7  SPI write address.
REQ-011 spi_wr_data  input  8  SPI write data.
REQ-012 duty_cycle  output  8  duty value driven to the PWM peripheral; registered.
REQ-013 busy  output  1  high while in WAIT or STEP.
REQ-014 done  output  1  one-cycle pulse when the ramp reaches cfg_target.
REQ-015 aborted  output  1  one-cycle pulse when an SPI duty write cancels an active ramp.

Function
REQ-016 States: IDLE, WAIT, STEP, DONE.
REQ-017 IDLE/DONE + start: latch target, step, period; load timer = period-1; go to WAIT.
REQ-018 WAIT: timer decrements by 1 per cycle; at timer==0 go to STEP.
REQ-019 STEP (exactly 1 cycle): duty < target -> duty = min(duty+step, target), using a 9-bit sum so no wrap; duty > target -> duty = max(duty-step, target), using a 9-bit signed compare so no underflow; duty == target -> no change.
REQ-020 STEP exit: new duty == target -> DONE; otherwise reload timer = period-1 and go to WAIT.
REQ-021 DONE: assert done for that single cycle; next state IDLE, or WAIT if start is present.
REQ-022 Latency: with start sampled on edge N, the first duty_cycle change is visible after edge N+period+1; each later step follows period+1 cycles after the previous one.
REQ-023 Start while busy: re-latch all cfg_* values and restart from the current duty_cycle in WAIT; no done or aborted pulse.
REQ-024 Start with cfg_target == current duty: go through one WAIT/STEP sequence, then DONE; done still pulses.
REQ-025 SPI duty write (spi_wr_valid && spi_wr_addr == DUTY_ADDR): duty_cycle = spi_wr_data on the next edge; state goes to IDLE.
REQ-026 The SPI duty write in REQ-025 asserts aborted only if the state was WAIT or STEP.
REQ-027 SPI writes to any other address are ignored.
REQ-028 SPI write and start on the same cycle: SPI write wins; start is dropped.
REQ-029 SPI write and STEP on the same cycle: SPI data wins; no done pulse.
REQ-030 done and aborted are never high together.

Reset
REQ-031 Asynchronous assertion of rst_n forces: state IDLE, duty_cycle 8'h00, timer 0, latched cfg 0, busy 0, done 0, aborted 0.
REQ-032 Reset mid-ramp discards the ramp; no done or aborted pulse is emitted on or after release.
REQ-033 Reset deassertion takes effect synchronously on the clk edge; the first start is honoured on the first edge after release.

Structure
REQ-034 Shared package pwm_ramp_pkg holds: the state enum, DUTY_ADDR default, and PERIOD_W default.
REQ-035 One sub-module, ramp_timer: load/decrement down-counter of width PERIOD_W with a zero flag.
REQ-036 All outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-037 Up-ramp: duty 0, start with target 10, step 3, period 4 -> duty 3,6,9,10 at 5-cycle spacing; done pulses once after duty reaches 10.
REQ-038 Down-ramp with clamp: duty 200, target 5, step 100, period 1 -> duty 100, then 5; no value below 5; done once.
REQ-039 Overflow guard: duty 250, target 255, step 20 -> single step to 255; no wrap to 14.
REQ-040 Abort: mid-ramp, SPI write addr 0x04 data 0x80 -> duty 0x80 next cycle; aborted=1 for 1 cycle; busy=0; no done.
REQ-041 Collisions: start and SPI write to 0x04 on the same cycle -> duty = SPI data, state IDLE. SPI write to 0x02 mid-ramp -> ramp unaffected.
REQ-042 Reset mid-WAIT: assert rst_n=0 -> duty 0x00, busy 0 immediately; no pulses after release. cfg_step=0 and cfg_period=0 -> behave as 1/1.
